// File: rtl/bank_xbar_req_arb.sv
// bank_xbar_req_arb
// Round-robin arbiter sharing one bank HTU request port among NUM_CH crossbar
// channels. The winning request is captured in a one-entry registered stage
// that drives the bank's HTU inputs; the stage drains and refills on the same
// edge, so the port sustains one request per cycle with one cycle of latency.
//
// Optional build macro: XBAR_ARB_WRITE_PRIO_EN
//   defined   - writes (opcode 2'b01) win over reads, round-robin within each
//               class on the shared pointer; a 3-bit write streak counter
//               forces a read grant after seven writes granted while reads wait.
//   undefined - opcode-blind round-robin.
//
// NUM_CH must be a power of two in the range 2..4 so the pointer wraps
// naturally in CH_W bits.

module bank_xbar_req_arb #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int DATA_W = 128
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        ch_req_valid_i,
    output logic [NUM_CH-1:0]        ch_req_allowIn_o,
    input  logic [2*NUM_CH-1:0]      ch_req_opcode_i,
    input  logic [28*NUM_CH-1:0]     ch_req_addr_i,
    input  logic [DATA_W*NUM_CH-1:0] ch_req_data_i,
    input  logic [8*NUM_CH-1:0]      ch_req_wbuffer_id_i,
    output logic                     arb_htu_valid_o,
    input  logic                     arb_htu_allowIn_i,
    output logic [CH_W-1:0]          arb_htu_ch_id_o,
    output logic [1:0]               arb_htu_opcode_o,
    output logic [27:0]              arb_htu_addr_o,
    output logic [DATA_W-1:0]        arb_htu_data_o,
    output logic [7:0]               arb_htu_wbuffer_id_o
);

    // First set bit of mask scanning upward from ptr with wrap; ptr when empty.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] mask,
                                                input logic [CH_W-1:0]   ptr);
        logic [CH_W-1:0] idx;
        logic [CH_W-1:0] pick;
        pick = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx  = ptr + CH_W'(i);
            pick = mask[idx] ? idx : pick;
        end
        return pick;
    endfunction

    // State
    logic [CH_W-1:0]   rr_ptr_r;
    logic              out_vld_r;
    logic [CH_W-1:0]   ch_id_r;
    logic [1:0]        opcode_r;
    logic [27:0]       addr_r;
    logic [DATA_W-1:0] data_r;
    logic [7:0]        wbid_r;

    // Combinational arbitration signals
    logic              any_vld_s;
    logic              slot_free_s;
    logic              grant_s;
    logic [NUM_CH-1:0] cand_s;
    logic [CH_W-1:0]   win_s;
    logic [NUM_CH-1:0] allow_s;
    logic [1:0]        sel_opcode_s;
    logic [27:0]       sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [7:0]        sel_wbid_s;

`ifdef XBAR_ARB_WRITE_PRIO_EN
    localparam logic [1:0] OP_WRITE = 2'b01;

    logic [2:0]        wr_streak_r;
    logic [2:0]        wr_streak_nxt_s;
    logic [NUM_CH-1:0] is_wr_s;
    logic [NUM_CH-1:0] wr_vld_s;
    logic [NUM_CH-1:0] rd_vld_s;

    // Split valid channels into write and read classes and pick the class to serve.
    always_comb begin
        is_wr_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            is_wr_s[k] = (ch_req_opcode_i[2*k +: 2] == OP_WRITE);
        end
        wr_vld_s = ch_req_valid_i & is_wr_s;
        rd_vld_s = ch_req_valid_i & ~is_wr_s;
        if ((wr_streak_r == 3'd7) && (|rd_vld_s)) begin
            cand_s = rd_vld_s;
        end else if (|wr_vld_s) begin
            cand_s = wr_vld_s;
        end else begin
            cand_s = rd_vld_s;
        end
    end

    // Next write-streak value: counts writes granted while reads are waiting.
    always_comb begin
        wr_streak_nxt_s = wr_streak_r;
        if (grant_s) begin
            if (is_wr_s[win_s] && (|rd_vld_s)) begin
                wr_streak_nxt_s = wr_streak_r + 3'd1;
            end else begin
                wr_streak_nxt_s = 3'd0;
            end
        end else if (!(|rd_vld_s)) begin
            wr_streak_nxt_s = 3'd0;
        end else begin
            wr_streak_nxt_s = wr_streak_r;
        end
    end

    // Write-streak register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_streak_r <= 3'd0;
        end else begin
            wr_streak_r <= wr_streak_nxt_s;
        end
    end
`else
    // Opcode-blind: every valid channel is a candidate.
    always_comb begin
        cand_s = ch_req_valid_i;
    end
`endif

    // Winner selection and channel accept; allowIn_o is gated off during reset.
    always_comb begin
        any_vld_s   = |ch_req_valid_i;
        slot_free_s = ~out_vld_r | arb_htu_allowIn_i;
        win_s       = rr_pick(cand_s, rr_ptr_r);
        grant_s     = slot_free_s & any_vld_s & rst_i;
        allow_s     = (NUM_CH'(1) << win_s) & {NUM_CH{grant_s}};
    end

    // Route the winning channel's fields toward the output stage.
    always_comb begin
        sel_opcode_s = 2'b00;
        sel_addr_s   = 28'd0;
        sel_data_s   = '0;
        sel_wbid_s   = 8'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel_opcode_s = (CH_W'(k) == win_s) ? ch_req_opcode_i[2*k +: 2]          : sel_opcode_s;
            sel_addr_s   = (CH_W'(k) == win_s) ? ch_req_addr_i[28*k +: 28]          : sel_addr_s;
            sel_data_s   = (CH_W'(k) == win_s) ? ch_req_data_i[DATA_W*k +: DATA_W]  : sel_data_s;
            sel_wbid_s   = (CH_W'(k) == win_s) ? ch_req_wbuffer_id_i[8*k +: 8]      : sel_wbid_s;
        end
    end

    // Output stage and round-robin pointer: refill on accept, drain when taken, hold on stall.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_ptr_r  <= '0;
            out_vld_r <= 1'b0;
            ch_id_r   <= '0;
            opcode_r  <= 2'b00;
            addr_r    <= 28'd0;
            data_r    <= '0;
            wbid_r    <= 8'd0;
        end else if (grant_s) begin
            rr_ptr_r  <= win_s + CH_W'(1);
            out_vld_r <= 1'b1;
            ch_id_r   <= win_s;
            opcode_r  <= sel_opcode_s;
            addr_r    <= sel_addr_s;
            data_r    <= sel_data_s;
            wbid_r    <= sel_wbid_s;
        end else if (arb_htu_allowIn_i) begin
            out_vld_r <= 1'b0;
        end
    end

    assign ch_req_allowIn_o     = allow_s;
    assign arb_htu_valid_o      = out_vld_r;
    assign arb_htu_ch_id_o      = ch_id_r;
    assign arb_htu_opcode_o     = opcode_r;
    assign arb_htu_addr_o       = addr_r;
    assign arb_htu_data_o       = data_r;
    assign arb_htu_wbuffer_id_o = wbid_r;

endmodule

// File: tb/tb_bank_xbar_req_arb.sv
// Testbench for bank_xbar_req_arb: scenario tasks with inline checks against a
// behavioural reference model of the round-robin rules (honours the optional
// XBAR_ARB_WRITE_PRIO_EN build macro).

module tb_bank_xbar_req_arb;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int DATA_W = 128;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_CH-1:0]        valid;
    logic [NUM_CH-1:0]        allow_o;
    logic [2*NUM_CH-1:0]      opc;
    logic [28*NUM_CH-1:0]     addr;
    logic [DATA_W*NUM_CH-1:0] data;
    logic [8*NUM_CH-1:0]      wbid;
    logic                     htu_valid;
    logic                     htu_allow;
    logic [CH_W-1:0]          htu_ch;
    logic [1:0]               htu_opc;
    logic [27:0]              htu_addr;
    logic [DATA_W-1:0]        htu_data;
    logic [7:0]               htu_wbid;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int                m_ptr;
    bit                m_vld;
    int                m_ch;
    logic [1:0]        m_op;
    logic [27:0]       m_addr;
    logic [DATA_W-1:0] m_data;
    logic [7:0]        m_wb;
    int                m_streak;

    bank_xbar_req_arb #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W)) dut (
        .clk_i               (clk),
        .rst_i               (rst_n),
        .ch_req_valid_i      (valid),
        .ch_req_allowIn_o    (allow_o),
        .ch_req_opcode_i     (opc),
        .ch_req_addr_i       (addr),
        .ch_req_data_i       (data),
        .ch_req_wbuffer_id_i (wbid),
        .arb_htu_valid_o     (htu_valid),
        .arb_htu_allowIn_i   (htu_allow),
        .arb_htu_ch_id_o     (htu_ch),
        .arb_htu_opcode_o    (htu_opc),
        .arb_htu_addr_o      (htu_addr),
        .arb_htu_data_o      (htu_data),
        .arb_htu_wbuffer_id_o(htu_wbid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_ptr = 0; m_vld = 0; m_ch = 0; m_op = 2'b00;
        m_addr = 28'd0; m_data = '0; m_wb = 8'd0; m_streak = 0;
    endfunction

    function automatic logic [NUM_CH-1:0] reads_waiting();
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_CH; k++) r[k] = valid[k] && (opc[2*k +: 2] != 2'b01);
        return r;
    endfunction

    // Channel that would be granted now, -1 if none (ignores slot occupancy).
    function automatic int model_pick();
        logic [NUM_CH-1:0] pool;
        pool = valid;
`ifdef XBAR_ARB_WRITE_PRIO_EN
        begin
            logic [NUM_CH-1:0] rd;
            rd = reads_waiting();
            if (m_streak >= 7 && rd != '0) pool = rd;
            else if ((valid & ~rd) != '0) pool = valid & ~rd;
            else pool = rd;
        end
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (pool[(m_ptr + i) % NUM_CH]) return (m_ptr + i) % NUM_CH;
        end
        return -1;
    endfunction

    function automatic int model_grant();
        if (m_vld && !htu_allow) return -1;
        return model_pick();
    endfunction

    function automatic logic [NUM_CH-1:0] model_allow();
        logic [NUM_CH-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic void model_step();
        int g;
        g = model_grant();
`ifdef XBAR_ARB_WRITE_PRIO_EN
        if (g >= 0) begin
            if (opc[2*g +: 2] == 2'b01 && reads_waiting() != '0) m_streak = m_streak + 1;
            else m_streak = 0;
        end else if (reads_waiting() == '0) begin
            m_streak = 0;
        end
`endif
        if (g >= 0) begin
            m_vld  = 1;
            m_ch   = g;
            m_op   = opc[2*g +: 2];
            m_addr = addr[28*g +: 28];
            m_data = data[DATA_W*g +: DATA_W];
            m_wb   = wbid[8*g +: 8];
            m_ptr  = (g + 1) % NUM_CH;
        end else if (htu_allow) begin
            m_vld = 0;
        end
    endfunction

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic randomize_payload();
        opc = 8'($urandom());
        for (int i = 0; i < NUM_CH * 28 / 28; i++) addr[28*i +: 28] = 28'($urandom());
        for (int i = 0; i < NUM_CH * DATA_W / 32; i++) data[32*i +: 32] = $urandom();
        wbid = $urandom();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; valid = '0; htu_allow = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        advance();
    endtask

    task automatic test_reset();
        valid = 4'b1111; htu_allow = 1'b1; opc = 8'h00;
        #1;
        total++;
        if ({htu_valid, htu_ch, htu_opc, htu_addr, htu_data, htu_wbid} !== '0) begin
            bad++; $display("FAIL reset_outputs: got %0h required 0",
                            {htu_valid, htu_ch, htu_opc, htu_addr, htu_data, htu_wbid});
        end
        total++;
        if (allow_o !== 4'b0000) begin
            bad++; $display("FAIL reset_allow: got %b required 0000", allow_o);
        end
        @(negedge clk);
        valid = '0; rst_n = 1'b1;
        model_reset();
        advance();
        total++;
        if (htu_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release_valid: got %b required 0", htu_valid);
        end
    endtask

    task automatic test_rotation();
        logic [NUM_CH-1:0] exp_allow;
        do_reset();
        opc = 8'h00; valid = 4'b1111; htu_allow = 1'b1;
        randomize_payload(); opc = 8'h00;
        for (int i = 0; i < 5; i++) begin
            #1;
            exp_allow = '0; exp_allow[i % NUM_CH] = 1'b1;
            total++;
            if (allow_o !== exp_allow || allow_o !== model_allow()) begin
                bad++; $display("FAIL rotation_allow[%0d]: got %b required %b", i, allow_o, exp_allow);
            end
            advance();
            total++;
            if (htu_valid !== 1'b1 || htu_ch !== CH_W'(i % NUM_CH) ||
                htu_addr !== addr[28*(i%NUM_CH) +: 28]) begin
                bad++; $display("FAIL rotation_out[%0d]: got v=%b ch=%0d addr=%0h required v=1 ch=%0d addr=%0h",
                                i, htu_valid, htu_ch, htu_addr, i % NUM_CH, addr[28*(i%NUM_CH) +: 28]);
            end
        end
    endtask

    task automatic test_wrap();
        opc = 8'h00; htu_allow = 1'b1; valid = 4'b0100;
        advance();               // ch2 granted, pointer moves to 3
        #1;
        total++;
        if (allow_o !== 4'b0100) begin
            bad++; $display("FAIL wrap_allow: got %b required 0100", allow_o);
        end
        advance();
        total++;
        if (htu_ch !== 2'd2 || htu_valid !== 1'b1) begin
            bad++; $display("FAIL wrap_ch: got ch=%0d v=%b required ch=2 v=1", htu_ch, htu_valid);
        end
        valid = 4'b1111;
        #1;
        total++;
        if (allow_o !== 4'b1000 || allow_o !== model_allow()) begin
            bad++; $display("FAIL wrap_ptr: got %b required 1000", allow_o);
        end
        advance();
    endtask

    task automatic test_stall();
        opc = 8'h00; htu_allow = 1'b1; valid = 4'b0010;
        addr[28*1 +: 28] = 28'h0ABCDEF;
        #1;
        total++;
        if (allow_o !== 4'b0010) begin
            bad++; $display("FAIL stall_accept: got %b required 0010", allow_o);
        end
        advance();
        htu_allow = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid = 4'($urandom_range(1, 15));
            #1;
            total++;
            if (allow_o !== 4'b0000) begin
                bad++; $display("FAIL stall_allow[%0d]: got %b required 0000", i, allow_o);
            end
            advance();
            total++;
            if (htu_valid !== 1'b1 || htu_ch !== 2'd1 || htu_addr !== 28'h0ABCDEF) begin
                bad++; $display("FAIL stall_hold[%0d]: got v=%b ch=%0d addr=%0h required v=1 ch=1 addr=abcdef",
                                i, htu_valid, htu_ch, htu_addr);
            end
        end
        valid = 4'b1111; htu_allow = 1'b1;
        #1;
        total++;
        if (allow_o === 4'b0000 || allow_o !== model_allow()) begin
            bad++; $display("FAIL stall_release: got %b required %b", allow_o, model_allow());
        end
        advance();
    endtask

    task automatic test_async_reset();
        opc = 8'h00; valid = 4'b1111; htu_allow = 1'b1;
        advance();
        htu_allow = 1'b0;
        advance();
        total++;
        if (htu_valid !== 1'b1) begin
            bad++; $display("FAIL areset_pre: got v=%b required 1", htu_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (htu_valid !== 1'b0 || htu_ch !== 2'd0 || allow_o !== 4'b0000) begin
            bad++; $display("FAIL areset_drop: got v=%b ch=%0d allow=%b required v=0 ch=0 allow=0000",
                            htu_valid, htu_ch, allow_o);
        end
        @(negedge clk);
        valid = '0; htu_allow = 1'b1; rst_n = 1'b1;
        model_reset();
        advance();
        valid = 4'b1111;
        #1;
        total++;
        if (allow_o !== 4'b0001) begin
            bad++; $display("FAIL areset_ptr: got %b required 0001", allow_o);
        end
        advance();
    endtask

    task automatic test_fairness();
        int cnt0 = 0;
        int cnt3 = 0;
        int prev = -1;
        int cur;
        opc = 8'h00; valid = 4'b1001; htu_allow = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            cur = (allow_o == 4'b0001) ? 0 : (allow_o == 4'b1000) ? 3 : -1;
            total++;
            if (cur < 0 || cur == prev || allow_o !== model_allow()) begin
                bad++; $display("FAIL fair_alt[%0d]: got %b required %b", i, allow_o, model_allow());
            end
            if (cur == 0) cnt0++;
            if (cur == 3) cnt3++;
            prev = cur;
            advance();
        end
        total++;
        if (cnt0 != 50 || cnt3 != 50) begin
            bad++; $display("FAIL fair_count: got ch0=%0d ch3=%0d required 50/50", cnt0, cnt3);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            valid = 4'($urandom());
            htu_allow = ($urandom_range(0, 9) < 7);
            randomize_payload();
            #1;
            total++;
            if (allow_o !== model_allow()) begin
                bad++; $display("FAIL rand_allow[%0d]: got %b required %b", i, allow_o, model_allow());
            end
            advance();
            total++;
            if (htu_valid !== m_vld ||
                {htu_ch, htu_opc, htu_addr, htu_data, htu_wbid} !== {CH_W'(m_ch), m_op, m_addr, m_data, m_wb}) begin
                bad++; $display("FAIL rand_out[%0d]: got v=%b %0h required v=%b %0h", i, htu_valid,
                                {htu_ch, htu_opc, htu_addr, htu_data, htu_wbid}, m_vld,
                                {CH_W'(m_ch), m_op, m_addr, m_data, m_wb});
            end
        end
    endtask

    task automatic test_write_prio();
        int exp_ch;
        logic [NUM_CH-1:0] exp_allow;
        do_reset();
        opc = 8'b01_01_01_00; valid = 4'b1111; htu_allow = 1'b1;
        for (int i = 0; i < 24; i++) begin
`ifdef XBAR_ARB_WRITE_PRIO_EN
            exp_ch = ((i % 8) == 7) ? 0 : ((i % 8) % 3) + 1;
`else
            exp_ch = i % NUM_CH;
`endif
            exp_allow = '0; exp_allow[exp_ch] = 1'b1;
            #1;
            total++;
            if (allow_o !== exp_allow || allow_o !== model_allow()) begin
                bad++; $display("FAIL prio_seq[%0d]: got %b required %b", i, allow_o, exp_allow);
            end
            advance();
        end
    endtask

    initial begin
        rst_n = 1'b0; valid = '0; htu_allow = 1'b0;
        opc = '0; addr = '0; data = '0; wbid = '0;
        model_reset();
        test_reset();
        test_rotation();
        test_wrap();
        test_stall();
        test_async_reset();
        test_fairness();
        test_random();
        test_write_prio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
